// File: rtl/coeff_dequant_buffer_pkg.sv
// rtl/coeff_dequant_buffer_pkg.sv - shared state types, zigzag map and dequant shift tables
// Build option: DEQUANT_SAT_EN selects saturating results instead of 16-bit wrap.
package coeff_dequant_buffer_pkg;

  typedef enum logic [1:0] {M1_IDLE, M1_FILL, M1_WAIT} m1_state_t;
  typedef enum logic [1:0] {M2_IDLE, M2_READ, M2_DONE} m2_state_t;

  typedef struct packed {
    logic [1:0] full;
    logic       wb;
    logic       rb;
  } bank_state_t;

  // Zigzag index k -> row-major {row,col} position.
  localparam logic [5:0] ZIGZAG [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  // Left-shift amount indexed by s = row + col (s never exceeds 14).
  localparam logic [2:0] Q0_SHIFT [16] = '{3, 1, 2, 2, 3, 3, 4, 4, 5, 5, 5, 5, 5, 5, 5, 5};
  localparam logic [2:0] Q1_SHIFT [16] = '{3, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2};

  function automatic logic [2:0] q_shift(input logic q, input logic [3:0] s);
    return q ? Q1_SHIFT[s] : Q0_SHIFT[s];
  endfunction

endpackage

// File: rtl/coeff_dequant_buffer_if.sv
// rtl/coeff_dequant_buffer_if.sv - coefficient stream and block read bus
interface coeff_dequant_buffer_if;
  logic        Q_select_I;
  logic        coeff_valid_I;
  logic [15:0] coeff_data_I;
  logic        coeff_ready_O;
  logic        block_ready_O;
  logic [5:0]  block_read_addr_I;
  logic [15:0] block_read_data_O;
  logic        block_release_I;
  logic        sat_flag_O;

  modport master (
    output Q_select_I, coeff_valid_I, coeff_data_I, block_read_addr_I, block_release_I,
    input  coeff_ready_O, block_ready_O, block_read_data_O, sat_flag_O
  );

  modport slave (
    input  Q_select_I, coeff_valid_I, coeff_data_I, block_read_addr_I, block_release_I,
    output coeff_ready_O, block_ready_O, block_read_data_O, sat_flag_O
  );
endinterface

// File: rtl/coeff_dequant_buffer_ram.sv
// rtl/coeff_dequant_buffer_ram.sv - 128x16 simple dual-port RAM holding both ping-pong banks
module dequant_bank_ram (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [6:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [6:0]  rd_addr,
  output logic [15:0] rd_data
);

  logic [15:0] mem [128];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/coeff_dequant_buffer.sv
// rtl/coeff_dequant_buffer.sv - zigzag dequantizer filling a ping-pong pair of 8x8 blocks
// Build option: DEQUANT_SAT_EN clamps out-of-range results and raises a sticky sat_flag_O.
module coeff_dequant_buffer
  import coeff_dequant_buffer_pkg::*;
(
  input  logic                 CLOCK_I,
  input  logic                 RESET_I,
  coeff_dequant_buffer_if.slave bus
);

  bank_state_t st, st_n;
  logic [5:0]  k;
  logic        q_lat;
  logic        xfer, rel, q_eff;
  logic [5:0]  pos;
  logic [3:0]  s;
  logic [2:0]  shift;
  logic [15:0] wr_data;

  assign bus.coeff_ready_O = ~st.full[st.wb];
  assign bus.block_ready_O = st.full[st.rb];
  assign xfer  = bus.coeff_valid_I & bus.coeff_ready_O;
  assign rel   = bus.block_release_I & bus.block_ready_O;

  // The block's matrix is taken from the first coefficient; later Q_select_I changes are ignored.
  assign q_eff = (k == 6'd0) ? bus.Q_select_I : q_lat;
  assign pos   = ZIGZAG[k];
  assign s     = {1'b0, pos[5:3]} + {1'b0, pos[2:0]};
  assign shift = q_shift(q_eff, s);

  // Completion and release can coincide; they always touch different banks.
  always_comb begin
    st_n = st;
    if (xfer && k == 6'd63) begin
      st_n.full[st.wb] = 1'b1;
      st_n.wb          = ~st.wb;
    end
    if (rel) begin
      st_n.full[st.rb] = 1'b0;
      st_n.rb          = ~st.rb;
    end
  end

  always_ff @(posedge CLOCK_I or posedge RESET_I) begin
    if (RESET_I) begin
      st    <= '0;
      k     <= '0;
      q_lat <= 1'b0;
    end else begin
      st <= st_n;
      if (xfer) begin
        k <= k + 6'd1;
        if (k == 6'd0) begin
          q_lat <= bus.Q_select_I;
        end
      end
    end
  end

`ifdef DEQUANT_SAT_EN
  logic signed [20:0] wide;
  logic               ovf;
  logic               sat_q;

  assign wide    = $signed({{5{bus.coeff_data_I[15]}}, bus.coeff_data_I}) <<< shift;
  assign ovf     = ~((&wide[20:15]) | ~(|wide[20:15]));
  assign wr_data = ovf ? (wide[20] ? 16'h8000 : 16'h7FFF) : wide[15:0];

  always_ff @(posedge CLOCK_I or posedge RESET_I) begin
    if (RESET_I) begin
      sat_q <= 1'b0;
    end else if (xfer && ovf) begin
      sat_q <= 1'b1;
    end
  end

  assign bus.sat_flag_O = sat_q;
`else
  assign wr_data        = bus.coeff_data_I << shift;
  assign bus.sat_flag_O = 1'b0;
`endif

  dequant_bank_ram u_ram (
    .clk     (CLOCK_I),
    .rst     (RESET_I),
    .we      (xfer),
    .wr_addr ({st.wb, pos}),
    .wr_data (wr_data),
    .rd_addr ({st.rb, bus.block_read_addr_I}),
    .rd_data (bus.block_read_data_O)
  );

endmodule

// File: tb/tb_coeff_dequant_buffer.sv
// tb/tb_coeff_dequant_buffer.sv - self-checking bench with a block-queue reference model
module tb_coeff_dequant_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  coeff_dequant_buffer_if bus();

  coeff_dequant_buffer dut (
    .CLOCK_I (clk),
    .RESET_I (rst),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: finished blocks as a queue, plus one block being assembled.
  typedef logic [15:0] blk_t [64];
  blk_t        fullq[$];
  blk_t        part;
  int          zz[64];
  int          pk = 0;
  int          pq = 0;
  logic [15:0] exp_rd = '0;
  bit          exp_rd_v = 1'b0;
  bit          exp_sat = 1'b0;

  function automatic void build_zigzag();
    int r = 0;
    int c = 0;
    for (int i = 0; i < 64; i++) begin
      zz[i] = r * 8 + c;
      if (((r + c) % 2) == 0) begin
        if (c == 7) r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == 7) c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
    end
  endfunction

  function automatic int shift_of(input int q, input int s);
    if (q == 0) begin
      if (s == 0) return 3;
      if (s == 1) return 1;
      if (s <= 3) return 2;
      if (s <= 5) return 3;
      if (s <= 7) return 4;
      return 5;
    end
    if (s == 0) return 3;
    if (s == 1) return 0;
    if (s <= 5) return 1;
    return 2;
  endfunction

  function automatic logic [15:0] deq(input logic signed [15:0] d, input int q, input int p, output bit ov);
    longint v;
    v  = longint'(d) * (longint'(1) << shift_of(q, p / 8 + p % 8));
    ov = (v > 32767) || (v < -32768);
`ifdef DEQUANT_SAT_EN
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`else
    ov = 1'b0;
`endif
    return v[15:0];
  endfunction

  always @(posedge clk) begin
    bit xf, rl, ov;
    if (rst) begin
      fullq.delete();
      pk = 0;
      pq = 0;
      exp_rd = '0;
      exp_rd_v = 1'b1;
      exp_sat = 1'b0;
    end else begin
      exp_rd_v = fullq.size() > 0;
      if (exp_rd_v) exp_rd = fullq[0][bus.block_read_addr_I];
      xf = bus.coeff_valid_I && (fullq.size() < 2);
      rl = bus.block_release_I && (fullq.size() > 0);
      if (rl) void'(fullq.pop_front());
      if (xf) begin
        if (pk == 0) pq = int'(bus.Q_select_I);
        part[zz[pk]] = deq(bus.coeff_data_I, pq, zz[pk], ov);
        if (ov) exp_sat = 1'b1;
        if (pk == 63) begin
          fullq.push_back(part);
          pk = 0;
        end else begin
          pk++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("coeff_ready", {31'b0, bus.coeff_ready_O}, {31'b0, fullq.size() < 2});
      check("block_ready", {31'b0, bus.block_ready_O}, {31'b0, fullq.size() > 0});
      if (exp_rd_v) check("read_data", {16'b0, bus.block_read_data_O}, {16'b0, exp_rd});
      check("sat_flag", {31'b0, bus.sat_flag_O}, {31'b0, exp_sat});
    end
  end

  task automatic send(input logic [15:0] d, input logic q, input logic rel = 1'b0);
    int n = 0;
    bus.coeff_valid_I   = 1'b1;
    bus.coeff_data_I    = d;
    bus.Q_select_I      = q;
    bus.block_release_I = rel;
    while (!bus.coeff_ready_O && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("send_timeout", n, 0);
    @(negedge clk);
    bus.coeff_valid_I   = 1'b0;
    bus.block_release_I = 1'b0;
  endtask

  task automatic read(input logic [5:0] a, output logic [15:0] d);
    bus.block_read_addr_I = a;
    @(negedge clk);
    d = bus.block_read_data_O;
  endtask

  task automatic release_blk();
    bus.block_release_I = 1'b1;
    @(negedge clk);
    bus.block_release_I = 1'b0;
  endtask

  logic [15:0] rd;

  initial begin
    bus.coeff_valid_I     = 1'b0;
    bus.coeff_data_I      = '0;
    bus.Q_select_I        = 1'b0;
    bus.block_read_addr_I = '0;
    bus.block_release_I   = 1'b0;
    build_zigzag();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_coeff_ready", {31'b0, bus.coeff_ready_O}, 1);
    check("rst_block_ready", {31'b0, bus.block_ready_O}, 0);
    check("rst_read_data", {16'b0, bus.block_read_data_O}, 0);
    check("rst_sat", {31'b0, bus.sat_flag_O}, 0);

    // All-ones block, Q0.
    for (int i = 0; i < 64; i++) send(16'd1, 1'b0);
    check("ones_block_ready", {31'b0, bus.block_ready_O}, 1);
    read(6'd0, rd);  check("ones_addr0", {16'b0, rd}, 8);
    read(6'd1, rd);  check("ones_addr1", {16'b0, rd}, 2);
    read(6'd63, rd); check("ones_addr63", {16'b0, rd}, 32);
    release_blk();

    // data = k, Q1 latched at k=0 while Q_select toggles afterwards.
    for (int i = 0; i < 64; i++) send(16'(i), (i == 0) ? 1'b1 : 1'(i & 1));
    for (int a = 0; a < 64; a++) read(6'(a), rd);
    read(6'd8, rd);  check("q1_addr8", {16'b0, rd}, 2);
    read(6'd9, rd);  check("q1_addr9", {16'b0, rd}, 8);
    read(6'd63, rd); check("q1_addr63", {16'b0, rd}, 252);
    release_blk();

    // Two blocks back to back with no release, then backpressure.
    for (int j = 0; j < 128; j++) send(16'(j * 3 - 50), (j < 64) ? 1'b0 : 1'b1);
    check("both_full_ready", {31'b0, bus.coeff_ready_O}, 0);
    bus.coeff_valid_I = 1'b1;
    bus.coeff_data_I  = 16'h1234;
    repeat (3) @(negedge clk);
    check("stall_ready", {31'b0, bus.coeff_ready_O}, 0);
    bus.block_release_I = 1'b1;
    @(negedge clk);
    bus.block_release_I = 1'b0;
    check("rel_coeff_ready", {31'b0, bus.coeff_ready_O}, 1);
    check("rel_block_ready", {31'b0, bus.block_ready_O}, 1);
    bus.coeff_valid_I = 1'b0;
    read(6'd0, rd); check("second_bank_addr0", {16'b0, rd}, 1136);
    release_blk();
    check("empty_block_ready", {31'b0, bus.block_ready_O}, 0);
    release_blk();
    check("idle_release_ready", {31'b0, bus.coeff_ready_O}, 1);

    // Reset mid-block discards the partial block.
    for (int i = 0; i < 30; i++) send(16'(i + 7), 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_block_ready", {31'b0, bus.block_ready_O}, 0);
    for (int i = 0; i < 64; i++) send(16'(100 - i), 1'b0);
    check("after_rst_ready", {31'b0, bus.block_ready_O}, 1);
    read(6'd0, rd); check("after_rst_addr0", {16'b0, rd}, 800);
    release_blk();

    // Completion and release in the same cycle.
    for (int i = 0; i < 64; i++) send(16'(i - 32), 1'b1);
    for (int i = 0; i < 63; i++) send(16'(2 * i + 5), 1'b0);
    send(16'(2 * 63 + 5), 1'b0, 1'b1);
    check("same_cycle_ready", {31'b0, bus.block_ready_O}, 1);
    check("same_cycle_coeff_ready", {31'b0, bus.coeff_ready_O}, 1);
    read(6'd0, rd);  check("same_cycle_addr0", {16'b0, rd}, 40);
    read(6'd63, rd); check("same_cycle_addr63", {16'b0, rd}, 4192);
    release_blk();

    // Overflow at the DC position.
    send(16'h7000, 1'b0);
    for (int i = 1; i < 64; i++) send(16'd0, 1'b0);
    read(6'd0, rd);
`ifdef DEQUANT_SAT_EN
    check("pos_ovf_addr0", {16'b0, rd}, 32'h7FFF);
    check("pos_ovf_sat", {31'b0, bus.sat_flag_O}, 1);
`else
    check("pos_ovf_addr0", {16'b0, rd}, 32'h8000);
    check("pos_ovf_sat", {31'b0, bus.sat_flag_O}, 0);
`endif
    release_blk();
    send(16'h9000, 1'b0);
    for (int i = 1; i < 64; i++) send(16'd0, 1'b0);
    read(6'd0, rd); check("neg_ovf_addr0", {16'b0, rd}, 32'h8000);
    release_blk();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/coeff_dequant_buffer.md
COEFF_DEQUANT_BUFFER -- requirements
Module: coeff_dequant_buffer

Interface
REQ-001 CLOCK_I  input  1  system clock, 50 MHz; all state on rising edge.
REQ-002 RESET_I  input  1  asynchronous, active-high reset.
REQ-003 Q_select_I  input  1  quantization matrix select: 0=Q0, 1=Q1.
REQ-004 coeff_valid_I  input  1  upstream decoder presents a coefficient.
REQ-005 coeff_data_I  input  16  signed quantized coefficient, zigzag order.
REQ-006 coeff_ready_O  output  1  block accepts coefficient this cycle.
REQ-007 block_ready_O  output  1  a complete dequantized 8x8 block is readable.
REQ-008 block_read_addr_I  input  6  row-major index {row[2:0],col[2:0]} into readable block.
REQ-009 block_read_data_O  output  16  signed dequantized coefficient.
REQ-010 block_release_I  input  1  consumer (IDCT stage) finished with readable block.
REQ-011 sat_flag_O  output  1  sticky saturation indicator (DEQUANT_SAT_EN only).

Function
REQ-012 Two 64x16 banks (ping-pong); per-bank full flag; write-bank pointer wb; read-bank pointer rb; zigzag counter k (6 bits).
REQ-013 coeff_ready_O SHALL equal ~full[wb], combinationally.
REQ-014 Transfer = coeff_valid_I && coeff_ready_O; non-transfer cycles change nothing on the write side.
REQ-015 On transfer with k==0, Q_select_I SHALL be latched and used for all 64 coefficients of that block; Q_select_I changes mid-block are ignored.
REQ-016 Position: (row,col) = zigzag(k), standard JPEG 8x8 zigzag; value written to bank[wb][row*8+col].
REQ-017 Shift by s=row+col. Q0: s=0:3, s=1:1, s=2-3:2, s=4-5:3, s=6-7:4, s>=8:5. Q1: s=0:3, s=1:0, s=2-5:1, s>=6:2.
REQ-018 Dequantized value = sign-extended coeff_data_I arithmetically shifted left by shift; result 16 bits per Configuration.
REQ-019 On transfer with k==63: full[wb]<=1, wb toggles, k<=0; otherwise k increments.
REQ-020 block_ready_O SHALL equal full[rb].
REQ-021 block_read_data_O SHALL be registered: value at bank[rb][block_read_addr_I] appears one cycle after the address; undefined content permitted when block_ready_O=0.
REQ-022 block_release_I while block_ready_O=1: full[rb]<=0, rb toggles; block_release_I while block_ready_O=0 is ignored.
REQ-023 Completion of bank wb and release of bank rb in the same cycle SHALL both take effect.
REQ-024 Both banks full: coeff_ready_O=0 until a release; upstream data held, none lost.
REQ-025 Throughput: one coefficient per cycle sustained while a bank is free; 64 cycles minimum per block.

Reset
REQ-026 RESET_I asserted: full[1:0]=0, wb=0, rb=0, k=0, latched Q=0, block_read_data_O=0, sat_flag_O=0; coeff_ready_O=1 and block_ready_O=0 after reset.
REQ-027 Reset mid-block discards partial and full blocks; bank RAM contents need not be cleared.

Configuration
REQ-028 Macro DEQUANT_SAT_EN defined: results outside [-32768,32767] SHALL clamp to the bound and set sat_flag_O (sticky until reset).
REQ-029 DEQUANT_SAT_EN undefined: result is low 16 bits of the shifted value (wrap); sat_flag_O tied to 0.

Structure
REQ-030 Zigzag LUT, Q0/Q1 shift tables and bank-state typedef SHALL live in the shared state-definition header alongside the M1/M2 state types.
REQ-031 One sub-module, dequant_bank_ram: 128x16 simple dual-port RAM (1 write port, 1 registered read port), address {bank,index}.

Verification
REQ-032 Reset, Q_select=0, stream 64 coeffs of value 1 -> block_ready_O=1 one cycle after 64th transfer; addr 0 reads 8, addr 1 reads 2, addr 63 (s=14) reads 32.
REQ-033 Stream k=0..63 with data=k, Q1 -> addr 8 (row1,col0; k=2) reads 2<<0=2; addr 9 (k=4, s=2) reads 8; rows/cols cover full zigzag map.
REQ-034 Fill both banks without release -> coeff_ready_O=0 after 128th transfer; release -> coeff_ready_O=1 next cycle, block_ready_O stays 1 (second bank).
REQ-035 Coefficient 0x7000, Q0 at k=0 -> DEQUANT_SAT_EN: reads 0x7FFF, sat_flag_O=1; without: reads 0x8000, sat_flag_O=0; -0x7000 -> 0x8000 saturated.
REQ-036 RESET_I pulse after 30 transfers -> block_ready_O=0, next 64 transfers form a complete block at bank 0 with correct values.
REQ-037 64th transfer and block_release_I in same cycle with rb!=wb -> block_ready_O stays 1, rb toggled, newly filled bank readable.
